// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state encoding, port indices, size-field width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memory_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_FLUSH,
    RD_SETTLE,
    RD_WAIT,
    WR_ISSUE,
    WR_WAIT
  } state_t;

  // Requester indices into the two-bit request/grant vectors.
  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  // Width of the controller's "words fetched" count, able to hold 0..wide_out.
  function automatic int size_w(input int wide_out);
    return $clog2(wide_out + 1);
  endfunction

endpackage

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on contention the port not granted last wins; data port first after reset.
// Latency: grant is combinational from req; the priority pointer moves at the edge where advance is high.
// Backpressure: none; the caller masks req while it is busy and pulses advance when a grant is taken.
// Ports: clk, reset (sync, active-high), req[1:0] {data, fetch}, advance, gnt[1:0] one-hot or zero.
module rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Index of the port that wins the next tie.
  logic prio;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

  // After serving fetch the data port gets priority, and vice versa.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= PORT_D;
    end else if (advance) begin
      prio <= gnt[PORT_F];
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a fetch read port and a data read/write port onto one memory controller.
// Latency: read 3 cycles req-to-done (4 when a flush of the stale address is needed); write depends on mem_write_ready.
// Backpressure: requesters hold req until done; writes stall in WR_ISSUE while mem_write_ready is low.
// Ports: clk/reset; fetch f_req/f_address -> f_done/f_data; data d_req/d_write/d_address/d_wdata -> d_done/d_rdata;
//        controller mem_write/mem_address/mem_in out, mem_write_ready/mem_out/mem_size in.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int RAM_WIDTH    = 8,
  parameter int RAM_DEPTH    = 16,
  parameter int MEM_WIDE_IN  = 1,
  parameter int MEM_WIDE_OUT = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  f_req,
  input  logic [RAM_DEPTH-1:0]                  f_address,
  output logic                                  f_done,
  output logic [RAM_WIDTH*MEM_WIDE_OUT-1:0]     f_data,
  input  logic                                  d_req,
  input  logic                                  d_write,
  input  logic [RAM_DEPTH-1:0]                  d_address,
  input  logic [RAM_WIDTH*MEM_WIDE_IN-1:0]      d_wdata,
  output logic                                  d_done,
  output logic [RAM_WIDTH*MEM_WIDE_OUT-1:0]     d_rdata,
  output logic                                  mem_write,
  input  logic                                  mem_write_ready,
  output logic [RAM_DEPTH-1:0]                  mem_address,
  output logic [RAM_WIDTH*MEM_WIDE_IN-1:0]      mem_in,
  input  logic [RAM_WIDTH*MEM_WIDE_OUT-1:0]     mem_out,
  input  logic [size_w(MEM_WIDE_OUT)-1:0]       mem_size
);

  localparam int SIZE_W = size_w(MEM_WIDE_OUT);
  localparam logic [SIZE_W-1:0] FULL_SIZE = SIZE_W'(MEM_WIDE_OUT);

  typedef struct packed {
    logic                 port;
    logic [RAM_DEPTH-1:0] addr;
  } txn_t;

  state_t               state, state_nxt;
  txn_t                 cur, grant_txn;
  logic                 grant_write;
  logic                 stale;
  logic                 wr_skip;
  logic [RAM_DEPTH-1:0] prev_addr;
  logic [1:0]           req_vec, gnt;
  logic                 grant_take, rd_done, wr_done;

  // While a done pulse is out the winning requester still holds req for the
  // finished transaction, so grants are suppressed for that cycle.
  assign req_vec = {d_req, f_req} & {2{(state == IDLE) && !f_done && !d_done}};

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req_vec),
    .advance (grant_take),
    .gnt     (gnt)
  );

  always_comb begin
    grant_txn.port = gnt[PORT_D];
    grant_txn.addr = gnt[PORT_D] ? d_address : f_address;
    grant_write    = gnt[PORT_D] & d_write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_write  = 1'b0;
    grant_take = 1'b0;
    rd_done    = 1'b0;
    wr_done    = 1'b0;
    case (state)
      IDLE: begin
        if (|gnt) begin
          grant_take = 1'b1;
          if (grant_write)  state_nxt = WR_ISSUE;
          else if (stale)   state_nxt = RD_FLUSH;
          else              state_nxt = RD_SETTLE;
        end
      end
      RD_FLUSH:  state_nxt = RD_SETTLE;
      RD_SETTLE: state_nxt = RD_WAIT;
      RD_WAIT: begin
        if ((mem_address == prev_addr) && (mem_size == FULL_SIZE)) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_ISSUE: begin
        if (mem_write_ready) begin
          mem_write = 1'b1;
          state_nxt = WR_WAIT;
        end
      end
      WR_WAIT: begin
        // The controller's ready flag is not meaningful the cycle after the strobe.
        if (!wr_skip && mem_write_ready) begin
          wr_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // State only leaves WR_ISSUE at the reset edge, so keep the strobe quiet meanwhile.
    if (reset) begin
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= '0;
      stale       <= 1'b1;
      wr_skip     <= 1'b0;
      prev_addr   <= '0;
      mem_address <= '0;
      mem_in      <= '0;
      f_data      <= '0;
      d_rdata     <= '0;
      f_done      <= 1'b0;
      d_done      <= 1'b0;
    end else begin
      f_done    <= 1'b0;
      d_done    <= 1'b0;
      prev_addr <= mem_address;

      if (grant_take) begin
        cur <= grant_txn;
        if (grant_write) begin
          mem_address <= grant_txn.addr;
          mem_in      <= d_wdata;
          stale       <= 1'b1;
        end else begin
          // A read after a write first presents the inverted address so the
          // controller sees an address change and drops any cached word.
          mem_address <= stale ? ~grant_txn.addr : grant_txn.addr;
        end
      end

      if (state == RD_FLUSH) begin
        mem_address <= cur.addr;
        stale       <= 1'b0;
      end

      if (state == WR_WAIT) wr_skip <= 1'b0;
      if (mem_write)        wr_skip <= 1'b1;

      if (rd_done) begin
        if (cur.port == PORT_D) begin
          d_rdata <= mem_out;
          d_done  <= 1'b1;
        end else begin
          f_data <= mem_out;
          f_done <= 1'b1;
        end
      end

      if (wr_done) d_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req, d_write;
  logic [15:0] f_address, d_address;
  logic [7:0]  d_wdata;
  logic        f_done, d_done, mem_write, mem_write_ready;
  logic [7:0]  f_data, d_rdata, mem_in, mem_out;
  logic [15:0] mem_address;
  logic [0:0]  mem_size;

  int n_cmp = 0;
  int n_bad = 0;
  int n_fdone = 0;
  int n_ddone = 0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .RAM_WIDTH(8), .RAM_DEPTH(16), .MEM_WIDE_IN(1), .MEM_WIDE_OUT(1)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_address(f_address), .f_done(f_done), .f_data(f_data),
    .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_write(mem_write), .mem_write_ready(mem_write_ready),
    .mem_address(mem_address), .mem_in(mem_in),
    .mem_out(mem_out), .mem_size(mem_size)
  );

  // Controller model: combinational read, busy for 2 cycles after each write strobe.
  logic [7:0] ram    [0:65535];
  logic [7:0] shadow [0:65535];
  int busy = 0;
  bit hold_off = 0;
  bit size_hold = 0;

  assign mem_write_ready = !hold_off && (busy == 0);
  assign mem_out  = ram[mem_address];
  assign mem_size = size_hold ? 1'b0 : 1'b1;

  always @(posedge clk) begin
    if (mem_write) begin
      ram[mem_address] <= mem_in;
      busy <= 2;
    end else if (busy > 0) begin
      busy <= busy - 1;
    end
  end

  // Scoreboard
  typedef struct { bit wr; logic [7:0] data; } exp_t;
  exp_t fq[$];
  exp_t dq[$];
  exp_t mon_e;
  logic [7:0] last_d_rd = 8'h00;

  always @(negedge clk) begin
    if (f_done || d_done) begin
      n_cmp++;
      if (f_done && d_done) begin
        n_bad++;
        $display("FAIL done_overlap: f_done=%b d_done=%b, required at most one", f_done, d_done);
      end
    end
    if (f_done) begin
      n_fdone++;
      n_cmp++;
      if (fq.size() == 0) begin
        n_bad++;
        $display("FAIL f_done_unexpected: pulse seen, none pending");
      end else begin
        mon_e = fq.pop_front();
        if (f_data !== mon_e.data) begin
          n_bad++;
          $display("FAIL f_data: got %h required %h", f_data, mon_e.data);
        end
      end
    end
    if (d_done) begin
      n_ddone++;
      n_cmp++;
      if (dq.size() == 0) begin
        n_bad++;
        $display("FAIL d_done_unexpected: pulse seen, none pending");
      end else begin
        mon_e = dq.pop_front();
        if (mon_e.wr) begin
          if (d_rdata !== last_d_rd) begin
            n_bad++;
            $display("FAIL d_rdata_hold_on_write: got %h required %h", d_rdata, last_d_rd);
          end
        end else begin
          if (d_rdata !== mon_e.data) begin
            n_bad++;
            $display("FAIL d_rdata: got %h required %h", d_rdata, mon_e.data);
          end
          last_d_rd = mon_e.data;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drivers
  task automatic issue_f(input logic [15:0] a);
    f_req = 1'b1;
    f_address = a;
    fq.push_back('{1'b0, shadow[a]});
  endtask

  task automatic issue_d(input bit wr, input logic [15:0] a, input logic [7:0] wd);
    d_req = 1'b1;
    d_write = wr;
    d_address = a;
    d_wdata = wd;
    if (wr) begin
      shadow[a] = wd;
      dq.push_back('{1'b1, 8'h00});
    end else begin
      dq.push_back('{1'b0, shadow[a]});
    end
  endtask

  task automatic wait_done(input bit is_d, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (is_d ? d_done : f_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    last_d_rd = 8'h00;
  endtask

  // Tests
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({f_done, d_done, mem_write} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b required 000", {f_done, d_done, mem_write});
    end
    n_cmp++;
    if (mem_address !== 16'h0000 || mem_in !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mem_bus: addr %h in %h required 0000 00", mem_address, mem_in);
    end
    n_cmp++;
    if (f_data !== 8'h00 || d_rdata !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_data: f %h d %h required 00 00", f_data, d_rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_first_read_flush;
    int c;
    @(posedge clk); #1;
    issue_f(16'h0040);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_address !== 16'hFFBF) begin
      n_bad++;
      $display("FAIL first_read_flush_addr: got %h required FFBF", mem_address);
    end
    wait_done(1'b0, 10, c);
    n_cmp++;
    if (c < 0 || c + 1 != 4) begin
      n_bad++;
      $display("FAIL first_read_latency: got %0d required 4", (c < 0) ? -1 : c + 1);
    end
    @(posedge clk); #1;
    f_req = 1'b0;
  endtask

  task automatic test_fetch_read;
    int c;
    @(posedge clk); #1;
    issue_f(16'h0010);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_address !== 16'h0010) begin
      n_bad++;
      $display("FAIL fetch_addr: got %h required 0010", mem_address);
    end
    wait_done(1'b0, 10, c);
    n_cmp++;
    if (c < 0 || c + 1 != 3) begin
      n_bad++;
      $display("FAIL fetch_latency: got %0d required 3", (c < 0) ? -1 : c + 1);
    end
    n_cmp++;
    if (f_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL fetch_data: got %h required a5", f_data);
    end
    @(posedge clk); #1;
    f_req = 1'b0;
  endtask

  task automatic test_contention;
    int nf, nd;
    bit got_d, exp_d, timed_out;
    pulse_reset();
    issue_f(16'h0031);
    issue_d(1'b0, 16'h0030, 8'h00);
    fq.push_back('{1'b0, shadow[16'h0031]});
    dq.push_back('{1'b0, shadow[16'h0030]});
    nf = 0;
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      timed_out = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (f_done || d_done) begin
          timed_out = 1'b0;
          break;
        end
      end
      n_cmp++;
      if (timed_out) begin
        n_bad++;
        $display("FAIL contention_timeout: round %0d no done within 20 cycles", k);
        break;
      end
      got_d = d_done;
      exp_d = (k % 2 == 0);
      if (got_d !== exp_d) begin
        n_bad++;
        $display("FAIL contention_order: round %0d got d=%b required d=%b", k, got_d, exp_d);
      end
      if (got_d) nd++; else nf++;
      if ((got_d && nd == 2) || (!got_d && nf == 2)) begin
        @(posedge clk); #1;
        if (got_d) d_req = 1'b0; else f_req = 1'b0;
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_write_flush;
    int c, strobes;
    bit seen;
    @(posedge clk); #1;
    issue_d(1'b1, 16'h0020, 8'h3C);
    @(posedge clk);
    strobes = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_write) begin
        strobes++;
        n_cmp++;
        if (mem_in !== 8'h3C || mem_address !== 16'h0020) begin
          n_bad++;
          $display("FAIL write_bus: addr %h in %h required 0020 3c", mem_address, mem_in);
        end
      end
      if (d_done) begin
        seen = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!seen || strobes != 1) begin
      n_bad++;
      $display("FAIL write_strobes: done=%b strobes %0d required 1 and 1", seen, strobes);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    d_write = 1'b0;
    @(posedge clk); #1;
    issue_d(1'b0, 16'h0020, 8'h00);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (mem_address !== 16'hFFDF) begin
      n_bad++;
      $display("FAIL flush_addr: got %h required ffdf", mem_address);
    end
    @(negedge clk);
    n_cmp++;
    if (mem_address !== 16'h0020) begin
      n_bad++;
      $display("FAIL flush_real_addr: got %h required 0020", mem_address);
    end
    wait_done(1'b1, 10, c);
    n_cmp++;
    if (c < 0 || c + 2 != 4) begin
      n_bad++;
      $display("FAIL flush_latency: got %0d required 4", (c < 0) ? -1 : c + 2);
    end
    n_cmp++;
    if (d_rdata !== 8'h3C) begin
      n_bad++;
      $display("FAIL flush_data: got %h required 3c", d_rdata);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic test_write_stall;
    int strobes, s, dn;
    hold_off = 1'b1;
    @(posedge clk); #1;
    issue_d(1'b1, 16'h0050, 8'h77);
    @(posedge clk);
    strobes = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_write) strobes++;
    end
    n_cmp++;
    if (strobes != 0) begin
      n_bad++;
      $display("FAIL stall_strobe: got %0d strobes while not ready, required 0", strobes);
    end
    @(posedge clk); #1;
    hold_off = 1'b0;
    s = -1;
    dn = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (mem_write) begin
        strobes++;
        s = i;
      end
      if (d_done) begin
        dn = i;
        break;
      end
    end
    n_cmp++;
    if (strobes != 1 || s < 0 || dn < 0 || dn - s != 4) begin
      n_bad++;
      $display("FAIL stall_release: strobes %0d strobe@%0d done@%0d required 1 strobe, done 4 after", strobes, s, dn);
    end
    n_cmp++;
    if (ram[16'h0050] !== 8'h77) begin
      n_bad++;
      $display("FAIL stall_mem_content: got %h required 77", ram[16'h0050]);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic test_reset_midread;
    int c, f0, d0;
    f0 = n_fdone;
    d0 = n_ddone;
    size_hold = 1'b1;
    @(posedge clk); #1;
    f_req = 1'b1;
    f_address = 16'h0070;
    @(posedge clk);
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    f_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({f_done, d_done, mem_write} !== 3'b000 || mem_address !== 16'h0000 || mem_in !== 8'h00
        || f_data !== 8'h00 || d_rdata !== 8'h00) begin
      n_bad++;
      $display("FAIL midread_reset_outputs: done %b%b wr %b addr %h in %h f %h d %h required all 0",
               f_done, d_done, mem_write, mem_address, mem_in, f_data, d_rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    size_hold = 1'b0;
    last_d_rd = 8'h00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (n_fdone != f0 || n_ddone != d0) begin
      n_bad++;
      $display("FAIL midread_no_done: got %0d f / %0d d pulses required 0", n_fdone - f0, n_ddone - d0);
    end
    @(posedge clk); #1;
    issue_d(1'b0, 16'h0010, 8'h00);
    @(posedge clk);
    wait_done(1'b1, 10, c);
    n_cmp++;
    if (c != 4) begin
      n_bad++;
      $display("FAIL post_reset_latency: got %0d required 4", c);
    end
    n_cmp++;
    if (d_rdata !== 8'hA5) begin
      n_bad++;
      $display("FAIL post_reset_data: got %h required a5", d_rdata);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    ram[16'h0010]    = 8'hA5;
    shadow[16'h0010] = 8'hA5;
    reset = 1'b1;
    f_req = 1'b0;
    d_req = 1'b0;
    d_write = 1'b0;
    f_address = '0;
    d_address = '0;
    d_wdata = '0;

    test_reset();
    test_first_read_flush();
    test_fetch_read();
    test_contention();
    test_write_flush();
    test_write_stall();
    test_reset_midread();

    repeat (4) @(posedge clk);
    n_cmp++;
    if (fq.size() != 0 || dq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d f / %0d d pending, required 0", fq.size(), dq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter RAM_WIDTH, 8, bits per RAM word.
REQ-002 Parameter RAM_DEPTH, 16, address width in bits.
REQ-003 Parameter MEM_WIDE_IN, 1, write word width in RAM words.
REQ-004 Parameter MEM_WIDE_OUT, 1, read word width in RAM words; SIZE_W = $clog2(MEM_WIDE_OUT+1).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 f_req  in  1  fetch-port read request, held until f_done.
REQ-008 f_address  in  RAM_DEPTH  fetch address, stable while f_req.
REQ-009 f_done  out  1  one-cycle pulse; f_data valid this cycle.
REQ-010 f_data  out  RAM_WIDTH*MEM_WIDE_OUT  fetch read data, held until the next f_done.
REQ-011 d_req  in  1  data-port request, held until d_done.
REQ-012 d_write  in  1  1 = write, 0 = read; stable while d_req.
REQ-013 d_address  in  RAM_DEPTH  data address, stable while d_req.
REQ-014 d_wdata  in  RAM_WIDTH*MEM_WIDE_IN  write data.
REQ-015 d_done  out  1  one-cycle completion pulse, both reads and writes.
REQ-016 d_rdata  out  RAM_WIDTH*MEM_WIDE_OUT  data read result, held until the next read d_done.
REQ-017 mem_write  out  1  write strobe to the memory controller.
REQ-018 mem_write_ready  in  1  controller idle/write-accept flag.
REQ-019 mem_address / mem_in  out  RAM_DEPTH / RAM_WIDTH*MEM_WIDE_IN  controller address and write data.
REQ-020 mem_out / mem_size  in  RAM_WIDTH*MEM_WIDE_OUT / SIZE_W  controller read data and number of words fetched.

Function
REQ-021 The FSM SHALL have states IDLE, RD_FLUSH, RD_SETTLE, RD_WAIT, WR_ISSUE and WR_WAIT.
REQ-022 In IDLE, a pending request SHALL be granted at the clock edge; mem_address (and mem_in for writes) SHALL be driven from the next cycle.
REQ-023 Arbitration SHALL be round-robin: on simultaneous f_req and d_req, the port not granted last wins; after reset, the data port wins first.
REQ-024 Read: IDLE->RD_SETTLE (1 cycle)->RD_WAIT; RD_WAIT SHALL exit when mem_address is unchanged and mem_size==MEM_WIDE_OUT.
REQ-025 On RD_WAIT exit, the arbiter SHALL register mem_out into f_data or d_rdata, pulse the matching done for 1 cycle, and return to IDLE.
REQ-026 Write: in WR_ISSUE the arbiter SHALL assert mem_write for exactly 1 cycle, only when mem_write_ready=1, otherwise it SHALL wait in WR_ISSUE with mem_write=0.
REQ-027 In WR_WAIT the arbiter SHALL ignore the cycle after the strobe, then wait for mem_write_ready=1, then pulse d_done and go to IDLE.
REQ-028 Any write SHALL set a stale flag; the next read SHALL pass through RD_FLUSH, driving ~address for 1 cycle, then the real address, and SHALL clear the flag.
REQ-029 The granted port's inputs SHALL be latched at grant; a dropped req mid-transaction SHALL NOT abort the transaction.
REQ-030 Minimum read latency (req sampled to done) SHALL be 3 cycles without a flush and 4 with a flush; a new grant SHALL occur no earlier than the cycle after done.
REQ-031 mem_write SHALL never be asserted during RD_* states; done pulses SHALL never overlap.

Reset
REQ-032 reset SHALL force state IDLE, the round-robin pointer to the data port, and the stale flag to 1.
REQ-033 reset SHALL force mem_write, f_done, d_done=0; mem_address, mem_in, f_data, d_rdata=0.
REQ-034 A reset during any state SHALL abandon the transaction with no done pulse.

Structure
REQ-035 A shared package SHALL hold the state enum and the SIZE_W derivation.
REQ-036 The round-robin grant logic SHALL be a sub-module, rr_arbiter2.

Verification
REQ-037 Fetch read at 0x0010, controller model returns 0xA5 (stale=0) -> f_done at cycle 3, f_data=0xA5.
REQ-038 Simultaneous f_req/d_req reads after reset -> d_done first, f_done next; repeated contention alternates grants.
REQ-039 d_write 0x3C to 0x0020, then d read of 0x0020 -> mem_address shows 0xFFDF for 1 cycle, then d_rdata=0x3C.
REQ-040 d_write while mem_write_ready=0 for 5 cycles -> mem_write held low; 1-cycle strobe after ready rises; d_done after ready returns.
REQ-041 reset asserted in RD_WAIT -> no done pulse; all outputs 0; next request served normally.
